// File: rtl/dpwm_duty_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dpwm_duty_scheduler_pkg
//   Shared definitions for the hybrid DPWM duty scheduler: default widths,
//   the duty clamp limit, the sequencer state encoding and the next-state
//   function of the sequencer.
// ---------------------------------------------------------------------------
package dpwm_duty_scheduler_pkg;

  localparam int N_BITS_DEF    = 6;
  localparam int FINE_BITS_DEF = 2;
  localparam int MAX_DUTY_DEF  = 62;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A RUN period that ends while enable is low goes straight to IDLE,
  // so the sequencer never starts a period it already knows it must drop.
  function automatic state_e fsm_next(input state_e cur, input logic enable,
                                      input logic wrap);
    state_e nxt;
    nxt = ST_IDLE;
    case (cur)
      ST_IDLE: begin
        if (enable) nxt = ST_RUN;
        else        nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (enable)    nxt = ST_RUN;
        else if (wrap) nxt = ST_IDLE;
        else           nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable)    nxt = ST_RUN;
        else if (wrap) nxt = ST_IDLE;
        else           nxt = ST_DRAIN;
      end
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dpwm_coarse_counter.sv
// ---------------------------------------------------------------------------
// dpwm_coarse_counter
//   C-bit free-running period counter of the hybrid DPWM.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   en_i     in  count enable (one increment per clk)
//   clear_i  in  synchronous clear to 0 (dominates en_i)
//   cnt_o    out current count
//   wrap_o   out combinational: the next enabled edge wraps 2^C-1 -> 0
// ---------------------------------------------------------------------------
module dpwm_coarse_counter #(
  parameter int C_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clear_i,
  output logic [C_BITS-1:0] cnt_o,
  output logic              wrap_o
);

  localparam logic [C_BITS-1:0] CNT_ONE = {{(C_BITS-1){1'b0}}, 1'b1};
  localparam logic [C_BITS-1:0] CNT_MAX = {C_BITS{1'b1}};

  logic [C_BITS-1:0] cnt_q;
  logic [C_BITS-1:0] cnt_d;

  // Next count: clear wins, otherwise increment with natural wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {C_BITS{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {C_BITS{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i && !clear_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/dpwm_duty_scheduler.sv
// ---------------------------------------------------------------------------
// dpwm_duty_scheduler
//   Sequencer of the hybrid DPWM. Owns the coarse period counter, buffers
//   duty updates from the compensator in a one-deep shadow register and
//   applies them only when the counter enters 0. Drives the coarse PWM level
//   and the phase-select / arm pulse of the 2-bit fine-edge stage.
//   clk          in  system clock, rising edge
//   rst          in  asynchronous active-low reset
//   enable       in  1 = run; 0 = finish the current period, then idle
//   duty_in      in  requested duty code (clamped to MAX_DUTY)
//   duty_valid   in  duty_in valid
//   duty_ready   out shadow register free
//   pwm_out      out coarse PWM level
//   fine_arm     out 1-clk pulse: fine stage extends the edge by phase_sel
//   phase_sel    out fine phase of the current period
//   period_start out 1-clk pulse on the first cycle of each running period
//   busy         out sequencer not idle
// ---------------------------------------------------------------------------
module dpwm_duty_scheduler
  import dpwm_duty_scheduler_pkg::*;
#(
  parameter int N_BITS    = N_BITS_DEF,
  parameter int FINE_BITS = FINE_BITS_DEF,
  parameter int MAX_DUTY  = MAX_DUTY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_BITS-1:0]    duty_in,
  input  logic                 duty_valid,
  output logic                 duty_ready,
  output logic                 pwm_out,
  output logic                 fine_arm,
  output logic [FINE_BITS-1:0] phase_sel,
  output logic                 period_start,
  output logic                 busy
);

  localparam int                C_BITS   = N_BITS - FINE_BITS;
  localparam logic [N_BITS-1:0] MAX_CODE = N_BITS'(MAX_DUTY);

  state_e                state_q;
  state_e                state_d;
  logic [N_BITS-1:0]     shadow_q;
  logic [N_BITS-1:0]     shadow_d;
  logic                  shadow_full_q;
  logic                  shadow_full_d;
  logic [N_BITS-1:0]     active_q;
  logic [N_BITS-1:0]     active_d;
  logic                  ready_q;
  logic                  pwm_q;
  logic                  arm_q;
  logic [FINE_BITS-1:0]  phase_q;
  logic                  pstart_q;
  logic                  busy_q;

  logic [C_BITS-1:0]     cnt_s;
  logic                  wrap_s;
  logic                  running_s;
  logic                  enter_zero_s;
  logic                  load_s;
  logic                  write_s;
  logic [N_BITS-1:0]     duty_clamped_s;
  logic [C_BITS-1:0]     coarse_s;
  logic [FINE_BITS-1:0]  fine_s;

  assign running_s = (state_q != ST_IDLE);

  dpwm_coarse_counter #(
    .C_BITS (C_BITS)
  ) u_coarse_counter (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (running_s),
    .clear_i (!running_s),
    .cnt_o   (cnt_s),
    .wrap_o  (wrap_s)
  );

  // cnt==0 is entered either by leaving IDLE (counter already parked at 0)
  // or by a wrap; both are the only points where a new duty may take effect.
  assign enter_zero_s   = ((state_q == ST_IDLE) && enable) || wrap_s;
  assign load_s         = enter_zero_s && shadow_full_q;
  assign write_s        = duty_valid && ready_q;
  assign duty_clamped_s = (duty_in > MAX_CODE) ? MAX_CODE : duty_in;
  assign coarse_s       = active_q[N_BITS-1:FINE_BITS];
  assign fine_s         = active_q[FINE_BITS-1:0];
  assign state_d        = fsm_next(state_q, enable, wrap_s);

  // Shadow/active next state. A write is only possible while the shadow is
  // empty and a load only while it is full, so the two never coincide.
  always_comb begin
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    if (load_s) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end else if (write_s) begin
      shadow_d      = duty_clamped_s;
      shadow_full_d = 1'b1;
    end else begin
      shadow_full_d = shadow_full_q;
    end
  end

  // Sequencer state, duty registers and registered output decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      shadow_q      <= {N_BITS{1'b0}};
      shadow_full_q <= 1'b0;
      active_q      <= {N_BITS{1'b0}};
      ready_q       <= 1'b1;
      pwm_q         <= 1'b0;
      arm_q         <= 1'b0;
      phase_q       <= {FINE_BITS{1'b0}};
      pstart_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      ready_q       <= !shadow_full_d;
      busy_q        <= (state_d != ST_IDLE);
      // Outputs decode the current count, so they trail it by one clk.
      pwm_q         <= running_s && (cnt_s < coarse_s);
      arm_q         <= running_s && (cnt_s == coarse_s) &&
                       (fine_s != {FINE_BITS{1'b0}});
      phase_q       <= running_s ? fine_s : {FINE_BITS{1'b0}};
      pstart_q      <= (state_q == ST_RUN) && (cnt_s == {C_BITS{1'b0}});
    end
  end

  assign duty_ready   = ready_q;
  assign pwm_out      = pwm_q;
  assign fine_arm     = arm_q;
  assign phase_sel    = phase_q;
  assign period_start = pstart_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dpwm_duty_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dpwm_duty_scheduler
//   Directed bench for dpwm_duty_scheduler (defaults N=6, F=2, MAX=62).
//   Each running period is sampled for 16 clks starting at its period_start
//   pulse; pwm/arm counts and positions are compared with hand-derived values.
// ---------------------------------------------------------------------------
module tb_dpwm_duty_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [5:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       fine_arm;
  logic [1:0] phase_sel;
  logic       period_start;
  logic       busy;

  int n_checks;
  int n_errors;

  // Per-period measurements, written by run_period.
  int r_pwm;
  int r_arm;
  int r_arm_idx;
  int r_ph0;
  int r_ph_chg;
  int r_rdy14;
  int r_rdy15;
  int r_busy_low;

  dpwm_duty_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .fine_arm     (fine_arm),
    .phase_sel    (phase_sel),
    .period_start (period_start),
    .busy         (busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for period_start, then samples 16 clks. Optionally writes
  // wr_val at index wr_idx and drives enable low at off_idx / high at on_idx.
  task automatic run_period(input int wr_idx, input logic [5:0] wr_val,
                            input int off_idx, input int on_idx);
    int guard;
    guard = 0;
    while (period_start !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    check_eq("period_start_found", 32'(period_start), 32'd1);
    r_pwm      = 0;
    r_arm      = 0;
    r_arm_idx  = -1;
    r_ph0      = int'(phase_sel);
    r_ph_chg   = 0;
    r_rdy14    = -1;
    r_rdy15    = -1;
    r_busy_low = -1;
    for (int i = 0; i < 16; i++) begin
      if (pwm_out) r_pwm++;
      if (fine_arm) begin
        r_arm++;
        r_arm_idx = i;
      end
      if (int'(phase_sel) != r_ph0) r_ph_chg++;
      if (i == 14) r_rdy14 = int'(duty_ready);
      if (i == 15) r_rdy15 = int'(duty_ready);
      if (!busy && r_busy_low < 0) r_busy_low = i;
      if (i == wr_idx) begin
        duty_in    = wr_val;
        duty_valid = 1'b1;
      end else begin
        duty_valid = 1'b0;
      end
      if (i == off_idx) enable = 1'b0;
      if (i == on_idx)  enable = 1'b1;
      step();
    end
    duty_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    enable     = 1'b0;
    duty_in    = 6'd0;
    duty_valid = 1'b0;

    // Reset state.
    @(posedge clk);
    #1;
    check_eq("rst_outs", {pwm_out, fine_arm, phase_sel, period_start, busy}, 32'd0);
    check_eq("rst_ready", 32'(duty_ready), 32'd1);
    #4 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("idle_outs", {pwm_out, fine_arm, phase_sel, period_start, busy}, 32'd0);
    end
    check_eq("idle_ready", 32'(duty_ready), 32'd1);

    // Write 0x15 while idle, then start.
    duty_in    = 6'h15;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    check_eq("s2_ready_full", 32'(duty_ready), 32'd0);
    enable = 1'b1;
    step();
    check_eq("s2_busy", 32'(busy), 32'd1);
    check_eq("s2_ready_loaded", 32'(duty_ready), 32'd1);
    check_eq("s2_no_early_start", 32'(period_start), 32'd0);
    run_period(-1, 6'd0, -1, -1);
    check_eq("s2_pwm", r_pwm, 5);
    check_eq("s2_arm_n", r_arm, 1);
    check_eq("s2_arm_idx", r_arm_idx, 5);
    check_eq("s2_phase", r_ph0, 1);
    check_eq("s2_period16", 32'(period_start), 32'd1);

    // Mid-period write 0x20: current period keeps 0x15.
    run_period(3, 6'h20, -1, -1);
    check_eq("s3_cur_pwm", r_pwm, 5);
    check_eq("s3_cur_arm_idx", r_arm_idx, 5);
    check_eq("s3_ph_stable", r_ph_chg, 0);
    check_eq("s3_ready_before_load", r_rdy14, 0);
    check_eq("s3_ready_after_load", r_rdy15, 1);
    run_period(2, 6'h3F, -1, -1);
    check_eq("s3_pwm8", r_pwm, 8);
    check_eq("s3_no_arm", r_arm, 0);
    check_eq("s3_phase0", r_ph0, 0);

    // Clamp 0x3F -> 62: coarse 15, fine 2.
    run_period(2, 6'h00, -1, -1);
    check_eq("s4_pwm15", r_pwm, 15);
    check_eq("s4_arm_n", r_arm, 1);
    check_eq("s4_arm_idx15", r_arm_idx, 15);
    check_eq("s4_phase2", r_ph0, 2);
    run_period(2, 6'h15, -1, -1);
    check_eq("s4_zero_pwm", r_pwm, 0);
    check_eq("s4_zero_arm", r_arm, 0);
    check_eq("s4_zero_phase", r_ph0, 0);

    // enable low at cnt 7: period completes, then idle.
    run_period(-1, 6'd0, 6, -1);
    check_eq("s5_drain_pwm", r_pwm, 5);
    check_eq("s5_drain_arm_idx", r_arm_idx, 5);
    check_eq("s5_busy_fall_idx", r_busy_low, 15);
    check_eq("s5_no_new_start", {period_start, pwm_out, fine_arm, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("s5_stays_idle", {period_start, pwm_out, fine_arm, busy}, 32'd0);
    end

    // 1-clk enable dip inside a period: no gap, waveform unchanged.
    enable = 1'b1;
    step();
    run_period(-1, 6'd0, 3, 4);
    check_eq("s5_dip_pwm", r_pwm, 5);
    check_eq("s5_dip_arm_idx", r_arm_idx, 5);
    check_eq("s5_dip_busy", r_busy_low, -1);
    check_eq("s5_dip_next_start", 32'(period_start), 32'd1);

    // Reset at cnt 9 with the shadow full.
    duty_in    = 6'h20;
    duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check_eq("s6_pre_ready", 32'(duty_ready), 32'd0);
    check_eq("s6_pre_busy_phase", {busy, phase_sel}, 32'd5);
    rst = 1'b0;
    #1;
    check_eq("s6_async_outs", {pwm_out, fine_arm, phase_sel, period_start, busy}, 32'd0);
    check_eq("s6_async_ready", 32'(duty_ready), 32'd1);
    enable = 1'b0;
    #2 rst = 1'b1;
    step();
    step();
    check_eq("s6_post_idle", {busy, duty_ready}, 32'd1);
    enable = 1'b1;
    step();
    run_period(-1, 6'd0, -1, -1);
    check_eq("s6_active0_pwm", r_pwm, 0);
    check_eq("s6_active0_arm", r_arm, 0);
    check_eq("s6_active0_phase", r_ph0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
